// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled 8N1 UART receiver feeding a first-word-fall-through RX FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   rx           asynchronous serial line, idle high
//   rd_en        pop the head entry (ignored when empty)
//   rd_data      FIFO head, valid while rx_valid=1 (driven 0 when empty)
//   rx_valid     FIFO non-empty
//   fifo_count   occupancy, 0..FIFO_DEPTH
//   frame_err    sticky: stop bit sampled 0
//   overrun_err  sticky: byte arrived while the FIFO was full
//   parity_err   sticky: even-parity mismatch (only with UART_RX_PARITY_EN)
//   err_clr      clears all sticky flags; a same-cycle error event wins
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the data bits.

module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  input  logic                          err_clr
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DivW-1:0]      div_cnt_q;
  logic                 tick;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push, frame_set;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 full, pop, wr_en, overrun_set;
  logic                 frame_err_q, overrun_err_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_set, parity_err_q;
`endif

  assign tick = (div_cnt_q == DivW'(Div - 1));

  // Receiver FSM. The start bit is sampled at its middle; every later sample is a full bit
  // period on, so data, parity and stop bits are all sampled mid-bit.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(OVERSAMPLE / 2 - 1)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            // Even parity: data bits xor parity bit must be 0.
            par_bad_d  = (^shreg_q) ^ rx_s_q;
            parity_set = par_bad_d;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == TickW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad_q;
`else
              push = 1'b1;
`endif
              state_d = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StWaitHi;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StWaitHi: begin
        // A held-low line (break) parks here so it cannot start a false frame.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full        = (count_q == CntW'(FIFO_DEPTH));
  assign pop         = rd_en && (count_q != '0);
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      div_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      div_cnt_q     <= tick ? '0 : div_cnt_q + 1'b1;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_q + CntW'(wr_en) - CntW'(pop);
      frame_err_q   <= frame_set | (frame_err_q & ~err_clr);
      overrun_err_q <= overrun_set | (overrun_err_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_set | (parity_err_q & ~err_clr);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shreg_q;
  end

  assign rx_valid    = (count_q != '0);
  assign rd_data     = rx_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n, rx, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       rx_valid, frame_err, overrun_err;
  logic [3:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int passed = 0;

  uart_rx_fifo #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [3:0] exp_count;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  // Stop-bit sample lands on the 11th rising edge of the stop bit; pop_at/clr_at are
  // asserted for exactly that edge. Leaves rx low after a bad stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_inv,
                            input logic pop_at, input logic clr_at, input logic chk_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_inv);
`endif
    rx = stop_bit;
    repeat (10) @(negedge clk);
    if (chk_lat) check("valid_before_stop_sample", 32'(rx_valid), 32'd0);
    rd_en   = pop_at;
    err_clr = clr_at;
    @(negedge clk);
    rd_en   = 1'b0;
    err_clr = 1'b0;
    if (chk_lat) check("valid_after_stop_sample", 32'(rx_valid), 32'd1);
    repeat (5) @(negedge clk);
    if (stop_bit) begin
      rx = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, exp_data: 8'hA5, exp_count: 4'd1};
    vecs[1] = '{data: 8'hFF, exp_data: 8'hFF, exp_count: 4'd1};
    vecs[2] = '{data: 8'h00, exp_data: 8'h00, exp_count: 4'd1};
    vecs[3] = '{data: 8'h81, exp_data: 8'h81, exp_count: 4'd1};
    vecs[4] = '{data: 8'h5A, exp_data: 8'h5A, exp_count: 4'd1};

    rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun_err", 32'(overrun_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Pop while empty must not move the read pointer.
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty_pop_count", 32'(fifo_count), 32'd0);
    check("empty_pop_valid", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'd0);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check($sformatf("vec%0d_popped_valid", i), 32'(rx_valid), 32'd0);
      check($sformatf("vec%0d_popped_count", i), 32'(fifo_count), 32'd0);
    end

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_overrun_err", 32'(overrun_err), 32'd0);

    // Framing error with err_clr on the same edge: the set must win.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("frame_err_set", 32'(frame_err), 32'd1);
    check("frame_err_count", 32'(fifo_count), 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("after_break_data", 32'(rd_data), 32'h11);
    check("after_break_count", 32'(fifo_count), 32'd1);
    pop_check("after_break_pop", 8'h11);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("frame_err_cleared", 32'(frame_err), 32'd0);

    // Overrun: nine bytes, no reads.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("overrun_count", 32'(fifo_count), 32'd8);
    check("overrun_flag", 32'(overrun_err), 32'd1);
    for (int i = 0; i < 8; i++) pop_check($sformatf("overrun_pop%0d", i), 8'(i));
    check("overrun_drained", 32'(fifo_count), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("overrun_cleared", 32'(overrun_err), 32'd0);

    // Full FIFO with a pop on the push edge.
    for (int i = 0; i < 8; i++) send_frame(8'h60 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(fifo_count), 32'd8);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("simul_count", 32'(fifo_count), 32'd8);
    check("simul_no_overrun", 32'(overrun_err), 32'd0);
    for (int i = 1; i < 8; i++) pop_check($sformatf("simul_pop%0d", i), 8'h60 + 8'(i));
    pop_check("simul_last", 8'h55);
    check("simul_drained", 32'(rx_valid), 32'd0);

    // Reset mid-frame with a byte stored and a sticky flag set.
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_count", 32'(fifo_count), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_valid", 32'(rx_valid), 32'd0);
    check("midreset_count", 32'(fifo_count), 32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("midreset_no_partial", 32'(fifo_count), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("parity_err_set", 32'(parity_err), 32'd1);
    check("parity_bad_count", 32'(fifo_count), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("parity_good_data", 32'(rd_data), 32'h0F);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("parity_err_cleared", 32'(parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
